// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage controller.
// Optional build macro: FETCH_PERF_COUNTERS_EN adds stall-cycle and
// accepted-flush event counters; without it the perf outputs read as zero.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSHED = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// Hazard-control, instruction-memory and IF/ID signals between the hazard
// unit / memory side (master) and the fetch stage controller (slave).
interface fetch_stage_ctrl_if;

    logic        PCoff;
    logic        IFID_writeOff;
    logic        flush;
    logic [31:0] redirect_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_valid;

    modport master (
        output PCoff, IFID_writeOff, flush, redirect_target, imem_rdata,
        input  imem_addr, IFID_Instruction, IFID_PCPlus4, IFID_valid
    );

    modport slave (
        input  PCoff, IFID_writeOff, flush, redirect_target, imem_rdata,
        output imem_addr, IFID_Instruction, IFID_PCPlus4, IFID_valid
    );

endinterface

// File: rtl/event_counter_32.sv
// Free-running 32-bit event counter: counts enabled cycles, wraps at 2^32.
module event_counter_32 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    // Count one per enabled cycle; synchronous clear.
    always_ff @(posedge Clk) begin
        if (Reset)
            count_reg <= 32'h0;
        else if (en)
            count_reg <= count_reg + 32'd1;
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID register, obeys the
// hazard unit's PCoff / IFID_writeOff / flush, and tracks stall streaks
// with a sticky deadlock flag.
// Optional build macro: FETCH_PERF_COUNTERS_EN (perf event counters).
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MAX_STALL   = 8,
    parameter int          STALL_CNT_W = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    fetch_stage_ctrl_if.slave      bus,
    output logic [1:0]             fetch_state,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   stall_timeout,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_flush_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [STALL_CNT_W-1:0] CNT_LIMIT = STALL_CNT_W'(MAX_STALL);

    fetch_state_t           state_reg, state_next;
    logic [31:0]            pc_reg, pc_next;
    logic [31:0]            instr_reg, instr_next;
    logic [31:0]            pc4_reg, pc4_next;
    logic                   valid_reg, valid_next;
    logic [STALL_CNT_W-1:0] cnt_reg, cnt_next;
    logic                   timeout_reg, timeout_next;
    logic [31:0]            pc_plus4;
    logic                   flush_ok;

    assign pc_plus4 = pc_reg + PC_INC;
    // A flush only takes effect when neither half of the pipeline is frozen.
    assign flush_ok = bus.flush && !bus.PCoff && !bus.IFID_writeOff;

    // Next-state logic for PC, IF/ID, FSM and stall tracking.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        pc4_next     = pc4_reg;
        valid_next   = valid_reg;
        cnt_next     = '0;
        timeout_next = timeout_reg;

        if (!bus.PCoff)
            pc_next = flush_ok ? {bus.redirect_target[31:2], 2'b00} : pc_plus4;

        if (!bus.IFID_writeOff) begin
            if (flush_ok) begin
                instr_next = NOP_INSTR;
                pc4_next   = 32'h0;
                valid_next = 1'b0;
            end else begin
                instr_next = bus.imem_rdata;
                pc4_next   = pc_plus4;
                valid_next = 1'b1;
            end
        end

        case (state_reg)
            RUN, FLUSHED: begin
                if (bus.PCoff)     state_next = STALL;
                else if (flush_ok) state_next = FLUSHED;
                else               state_next = RUN;
            end
            STALL: begin
                if (!bus.PCoff)
                    state_next = flush_ok ? FLUSHED : RUN;
            end
            default: state_next = RUN;
        endcase

        if (bus.PCoff)
            cnt_next = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

        if (cnt_next == CNT_LIMIT)
            timeout_next = 1'b1;
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= RUN;
            pc_reg      <= RESET_PC;
            instr_reg   <= NOP_INSTR;
            pc4_reg     <= 32'h0;
            valid_reg   <= 1'b0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            pc4_reg     <= pc4_next;
            valid_reg   <= valid_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.imem_addr        = pc_reg;
    assign bus.IFID_Instruction = instr_reg;
    assign bus.IFID_PCPlus4     = pc4_reg;
    assign bus.IFID_valid       = valid_reg;
    assign fetch_state          = state_reg;
    assign stall_count          = cnt_reg;
    assign stall_timeout        = timeout_reg;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [1:0]  perf_en;
    logic [31:0] perf_val [2];

    assign perf_en[0] = bus.PCoff;
    assign perf_en[1] = flush_ok;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        event_counter_32 u_cnt (
            .Clk   (Clk),
            .Reset (Reset),
            .en    (perf_en[gi]),
            .count (perf_val[gi])
        );
    end

    assign perf_stall_cycles = perf_val[0];
    assign perf_flush_count  = perf_val[1];
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Randomized bench for fetch_stage_ctrl against a cycle-level reference model.
module tb_fetch_stage_ctrl;
    import fetch_pkg::*;

    localparam int W    = 4;
    localparam int MAXS = 8;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    fetch_stage_ctrl_if bus();
    logic [1:0]   fetch_state;
    logic [W-1:0] stall_count;
    logic         stall_timeout;
    logic [31:0]  perf_stall_cycles, perf_flush_count;

    fetch_stage_ctrl #(.RESET_PC(32'h0), .MAX_STALL(MAXS), .STALL_CNT_W(W)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .bus               (bus),
        .fetch_state       (fetch_state),
        .stall_count       (stall_count),
        .stall_timeout     (stall_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model, advanced once per clock from the architectural rules.
    logic [31:0] m_pc, m_instr, m_pc4, m_pst, m_pfl;
    logic        m_valid, m_to;
    logic [1:0]  m_state;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit pcoff, input bit wo, input bit fl,
                        input logic [31:0] tgt, input logic [31:0] rdata);
        bit take;
        Reset               = rst;
        bus.PCoff           = pcoff;
        bus.IFID_writeOff   = wo;
        bus.flush           = fl;
        bus.redirect_target = tgt;
        bus.imem_rdata      = rdata;

        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_state = RUN; m_cnt = 0; m_to = 1'b0; m_pst = 32'h0; m_pfl = 32'h0;
        end else begin
            take = fl && !pcoff && !wo;
            if (!wo) begin
                if (take) begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end else begin
                    m_instr = rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end
            end
            if (!pcoff)
                m_pc = take ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_state = pcoff ? STALL : (take ? FLUSHED : RUN);
            m_cnt   = pcoff ? ((m_cnt < (1 << W) - 1) ? m_cnt + 1 : m_cnt) : 0;
            if (m_cnt == MAXS) m_to = 1'b1;
            if (pcoff) m_pst = m_pst + 32'd1;
            if (take)  m_pfl = m_pfl + 32'd1;
        end

        @(posedge Clk);
        #1;
        check_eq("pc",      bus.imem_addr,        m_pc);
        check_eq("instr",   bus.IFID_Instruction, m_instr);
        check_eq("pcplus4", bus.IFID_PCPlus4,     m_pc4);
        check_eq("valid",   {31'h0, bus.IFID_valid}, {31'h0, m_valid});
        check_eq("state",   {30'h0, fetch_state}, {30'h0, m_state});
        check_eq("stallcnt", {28'h0, stall_count}, 32'(m_cnt));
        check_eq("timeout", {31'h0, stall_timeout}, {31'h0, m_to});
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("perf_stall", perf_stall_cycles, m_pst);
        check_eq("perf_flush", perf_flush_count,  m_pfl);
`else
        check_eq("perf_stall", perf_stall_cycles, 32'h0);
        check_eq("perf_flush", perf_flush_count,  32'h0);
`endif
        $display("[TB] t=%0t rst=%0b pcoff=%0b wo=%0b fl=%0b tgt=%h -> pc=%h ifid=%h/%h v=%0b st=%0d cnt=%0d to=%0b",
                 $time, rst, pcoff, wo, fl, tgt, bus.imem_addr, bus.IFID_Instruction,
                 bus.IFID_PCPlus4, bus.IFID_valid, fetch_state, stall_count, stall_timeout);
    endtask

    initial begin
        Reset = 1'b1;
        bus.PCoff = 1'b0; bus.IFID_writeOff = 1'b0; bus.flush = 1'b0;
        bus.redirect_target = 32'h0; bus.imem_rdata = 32'h0;

        // Reset, then free-running fetch.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h8C01_0004);
        step(0, 0, 0, 0, 32'h0, 32'h0022_1820);
        step(0, 0, 0, 0, 32'h0, 32'h1000_0002);
        check_eq("plan_ifid_third", bus.IFID_Instruction, 32'h1000_0002);
        check_eq("plan_pc_c", bus.imem_addr, 32'h0000_000C);
        step(0, 0, 0, 0, 32'h0, 32'h0000_0013);

        // Two-cycle full stall at PC=0x10, then release.
        step(0, 1, 1, 0, 32'h0, 32'hDEAD_BEEF);
        step(0, 1, 1, 0, 32'h0, 32'hDEAD_BEEF);
        check_eq("plan_stall_pc", bus.imem_addr, 32'h0000_0010);
        check_eq("plan_stall_cnt", {28'h0, stall_count}, 32'd2);
        step(0, 0, 0, 0, 32'h0, 32'h0000_0033);
        check_eq("plan_release_pc", bus.imem_addr, 32'h0000_0014);

        // Flush with unaligned target, then one RUN cycle.
        step(0, 0, 0, 1, 32'h0000_0043, 32'h1111_1111);
        check_eq("plan_flush_pc", bus.imem_addr, 32'h0000_0040);
        step(0, 0, 0, 0, 32'h0, 32'h2222_2222);

        // Flush during stall is ignored; retried flush is taken.
        step(0, 1, 0, 1, 32'h0000_0100, 32'h3333_3333);
        step(0, 0, 0, 1, 32'h0000_0100, 32'h4444_4444);
        check_eq("plan_retry_pc", bus.imem_addr, 32'h0000_0100);

        // Ten-cycle stall crosses the timeout threshold; flag is sticky.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 32'h0, $urandom);
            if (i == 6) check_eq("plan_to_before", {31'h0, stall_timeout}, 32'd0);
            if (i == 7) check_eq("plan_to_at8",    {31'h0, stall_timeout}, 32'd1);
        end
        step(0, 0, 0, 0, 32'h0, $urandom);
        check_eq("plan_to_sticky", {31'h0, stall_timeout}, 32'd1);

        // Counter saturation on a long stall.
        for (int i = 0; i < 18; i++) step(0, 1, 1, 0, 32'h0, $urandom);
        check_eq("plan_cnt_sat", {28'h0, stall_count}, 32'd15);

        // PC wrap from 0xFFFF_FFFC.
        step(0, 0, 0, 1, 32'hFFFF_FFFF, $urandom);
        check_eq("plan_pc_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0, 32'h5555_5555);
        check_eq("plan_pc_wrap", bus.imem_addr, 32'h0);
        check_eq("plan_pc4_wrap", bus.IFID_PCPlus4, 32'h0);

        // Reset during a stall.
        step(0, 1, 1, 1, 32'h0000_0200, $urandom);
        step(1, 1, 1, 1, 32'h0000_0200, $urandom);
        check_eq("plan_rst_to", {31'h0, stall_timeout}, 32'd0);

        // Randomized traffic with occasional resets and long stalls.
        for (int i = 0; i < 400; i++) begin
            bit r, p, w, f;
            r = ($urandom_range(0, 59) == 0);
            if ((i % 90) >= 70) p = 1'b1;
            else                p = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 1) == 0) ? p : ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 3) == 0);
            step(r, p, w, f, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
